// File: rtl/qlearn_pkg.sv
// Shared definitions for the Q-learning transition generator.
// Holds the grid geometry, action encodings, FSM states and the grid move rule.
package qlearn_pkg;

    localparam int STATE_W = 6;
    localparam int ACT_W   = 2;

    localparam logic [2:0] GRID_MAX = 3'd7;

    localparam logic [ACT_W-1:0] ACT_LEFT  = 2'b00;
    localparam logic [ACT_W-1:0] ACT_UP    = 2'b01;
    localparam logic [ACT_W-1:0] ACT_RIGHT = 2'b10;
    localparam logic [ACT_W-1:0] ACT_DOWN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_CHOOSE,
        ST_EMIT
    } fsm_state_t;

    // One move on the 8x8 grid; a move into a wall leaves the state unchanged.
    // Row and column are updated independently, so nothing carries between fields.
    function automatic logic [STATE_W-1:0] grid_step(input logic [STATE_W-1:0] s,
                                                     input logic [ACT_W-1:0]   a);
        logic [2:0] x;
        logic [2:0] y;
        x = s[5:3];
        y = s[2:0];
        case (a)
            ACT_LEFT:  if (y != 3'd0)     y = y - 3'd1;
            ACT_UP:    if (x != 3'd0)     x = x - 3'd1;
            ACT_RIGHT: if (y != GRID_MAX) y = y + 3'd1;
            default:   if (x != GRID_MAX) x = x + 3'd1;
        endcase
        return {x, y};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, taps 16,14,13,11; steps only when en is high.
// SEED must be nonzero or the register locks at zero.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] q
);

    logic feedback;

    assign feedback = q[15] ^ q[13] ^ q[12] ^ q[10];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[14:0], feedback};
        end
    end

endmodule

// File: rtl/transition_gen.sv
// Epsilon-greedy (s, a, s') tuple generator for an 8x8 grid world.
// Looks up the greedy action, optionally explores via LFSR, and hands tuples off with valid/ready.
module transition_gen #(
    parameter int          STATE_W = qlearn_pkg::STATE_W,
    parameter int          ACT_W   = qlearn_pkg::ACT_W,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] start_state,
    input  logic [STATE_W-1:0] goal_state,
    input  logic [7:0]         eps,
    input  logic [15:0]        max_episodes,
    output logic [STATE_W-1:0] greedy_addr,
    input  logic [ACT_W-1:0]   greedy_act,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_s,
    output logic [ACT_W-1:0]   out_a,
    output logic [STATE_W-1:0] out_snext,
    output logic               out_last,
    output logic [15:0]        episode_cnt,
    output logic               busy
);

    import qlearn_pkg::*;

    fsm_state_t         state;
    fsm_state_t         state_next;

    logic [STATE_W-1:0] s;
    logic [ACT_W-1:0]   greedy_q;
    logic [15:0]        lfsr_q;
    logic               lfsr_unused;

    logic               explore;
    logic [ACT_W-1:0]   act_sel;
    logic [STATE_W-1:0] snext;
    logic               accept;
    logic [15:0]        cnt_inc;
    logic               run_done;

    lfsr16 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (state == ST_CHOOSE),
        .q   (lfsr_q)
    );

    // Only the low ten bits drive decisions; the rest only feed the shift chain.
    assign lfsr_unused = ^lfsr_q[15:10];

    assign explore = (lfsr_q[7:0] < eps);
    assign act_sel = explore ? lfsr_q[9:8] : greedy_q;
    assign snext   = grid_step(s, act_sel);

    assign accept   = out_valid & out_ready;
    assign cnt_inc  = (episode_cnt == 16'hFFFF) ? 16'hFFFF : episode_cnt + 16'd1;
    assign run_done = (max_episodes != 16'd0) && (cnt_inc >= max_episodes);

    // s is held stable from LOOKUP through WAIT, so the table sees a steady address.
    assign greedy_addr = s;
    assign out_valid   = (state == ST_EMIT);
    assign busy        = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_LOOKUP;
            ST_LOOKUP: state_next = ST_WAIT;
            ST_WAIT:   state_next = ST_CHOOSE;
            ST_CHOOSE: state_next = ST_EMIT;
            ST_EMIT: begin
                if (accept) begin
                    state_next = (out_last && run_done) ? ST_IDLE : ST_LOOKUP;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s           <= '0;
            greedy_q    <= '0;
            out_s       <= '0;
            out_a       <= '0;
            out_snext   <= '0;
            out_last    <= 1'b0;
            episode_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        s           <= start_state;
                        episode_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    greedy_q <= greedy_act;
                end
                ST_CHOOSE: begin
                    out_s     <= s;
                    out_a     <= act_sel;
                    out_snext <= snext;
                    out_last  <= (snext == goal_state);
                end
                ST_EMIT: begin
                    // Tuple registers stay untouched here, which keeps them stable under backpressure.
                    if (accept) begin
                        if (out_last) begin
                            episode_cnt <= cnt_inc;
                            if (!run_done) s <= start_state;
                        end else begin
                            s <= out_snext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/transition_gen.md
TRANSITION_GEN -- requirements
Module: transition_gen

Interface
REQ-001 Parameter STATE_W, default 6, state index width; bits [5:3] = x (row), bits [2:0] = y (column), 8x8 grid.
REQ-002 Parameter ACT_W, default 2, action width; 00 left, 01 up, 10 right, 11 down.
REQ-003 Parameter SEED, default 16'hACE1, LFSR reset value; SHALL be nonzero.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a run when in IDLE.
REQ-007 start_state  in  6  state loaded at the start of every episode.
REQ-008 goal_state  in  6  terminal state.
REQ-009 eps  in  8  exploration threshold; explore when lfsr[7:0] < eps.
REQ-010 max_episodes  in  16  run length; 0 means unbounded.
REQ-011 greedy_addr  out  6  state address to the greedy-action table.
REQ-012 greedy_act  in  2  greedy-table read data, valid exactly 1 cycle after greedy_addr is presented.
REQ-013 out_valid  out  1  tuple valid.
REQ-014 out_ready  in  1  downstream Q-update pipeline accepts the tuple.
REQ-015 out_s, out_a, out_snext  out  6/2/6  current state, chosen action, next state.
REQ-016 out_last  out  1  out_snext equals goal_state.
REQ-017 episode_cnt  out  16  number of completed episodes.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, LOOKUP, WAIT, CHOOSE, EMIT.
- IDLE -> LOOKUP on start: s <= start_state.
- LOOKUP -> WAIT: drives greedy_addr = s.
- WAIT -> CHOOSE: registers greedy_act.
- CHOOSE -> EMIT: computes a and snext.
- EMIT holds until out_valid & out_ready, then goes to LOOKUP or IDLE.
REQ-020 In CHOOSE: if lfsr[7:0] < eps, a SHALL be lfsr[9:8]; otherwise a SHALL be the registered greedy_act. eps = 0 never explores; eps = 255 explores unless lfsr[7:0] = 255.
REQ-021 The 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance exactly once per CHOOSE cycle and SHALL hold in all other states.
REQ-022 Wall rule: snext = s when (y = 0 and a = left), (x = 0 and a = up), (y = 7 and a = right), or (x = 7 and a = down). Otherwise left is y-1, right is y+1, up is x-1, down is x+1. There is no wrap-around and no carry between fields.
REQ-023 out_s, out_a, out_snext and out_last SHALL be stable while out_valid is high and out_ready is low. out_valid SHALL NOT drop before acceptance.
REQ-024 On acceptance with out_last = 0: s <= snext, next state LOOKUP.
REQ-025 On acceptance with out_last = 1:
- episode_cnt increments, saturating at 16'hFFFF.
- If max_episodes != 0 and the incremented count >= max_episodes, next state is IDLE.
- Otherwise s <= start_state and next state is LOOKUP.
REQ-026 If start_state = goal_state, the first tuple SHALL still be emitted, with out_last decided from snext.
REQ-027 start SHALL be ignored outside IDLE. start in IDLE SHALL clear episode_cnt.
REQ-028 Minimum spacing is 4 cycles per tuple when out_ready is held high.

Reset
REQ-029 rst SHALL force: state IDLE; out_valid, out_last, busy = 0; episode_cnt = 0; lfsr = SEED; s, out_s, out_a, out_snext, greedy_addr = 0.
REQ-030 rst asserted mid-episode, including during EMIT with out_ready low, SHALL abandon the tuple. out_valid SHALL be 0 on the cycle after reset is sampled.

Structure
REQ-031 The shared package qlearn_pkg SHALL hold:
- STATE_W and ACT_W.
- Action encodings ACT_LEFT, ACT_UP, ACT_RIGHT, ACT_DOWN.
- The grid bound GRID_MAX = 7.
- The FSM state enumeration.
REQ-032 The LFSR SHALL be a separate sub-module, lfsr16, with ports clk, rst, en, and q[15:0].

Verification
REQ-033 Walls: s = 6'b000_000, eps = 255, forced a = up -> out_snext = 000_000; a = right -> out_snext = 000_001.
REQ-034 Greedy: eps = 0, greedy_act = 10, s = 100_001 -> tuple (100_001, 10, 100_010) appears 4 cycles after start.
REQ-035 Backpressure: out_ready low for 10 cycles during EMIT -> out_valid stays high and the tuple is unchanged; LFSR value is identical before and after the stall.
REQ-036 Episode end: start_state = 111_110, goal = 111_111, eps = 0, greedy = right, max_episodes = 2 -> two tuples with out_last = 1, episode_cnt = 2, then IDLE with busy = 0.
REQ-037 Reset: rst during EMIT -> next cycle out_valid = 0, episode_cnt = 0, lfsr = SEED.
REQ-038 Exploration: eps = 128, 10,000 tuples -> each action frequency is within 25% ± 2% of the explored tuples; no snext ever leaves the grid.
